// File: rtl/gm_hook_pkg.sv
// rtl/gm_hook_pkg.sv - shared hook enums and default limits
package gm_hook_pkg;

  typedef enum logic [1:0] {
    MODE_SWING   = 2'd0,
    MODE_EXTEND  = 2'd1,
    MODE_RETRACT = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    PHASE_IDLE   = 2'd0,
    PHASE_UPDATE = 2'd1,
    PHASE_KICK   = 2'd2,
    PHASE_WAIT   = 2'd3
  } phase_t;

  // Limits shared with the hook drawer and collision logic
  localparam int unsigned GM_DEG_MIN      = 20;
  localparam int unsigned GM_DEG_MAX      = 160;
  localparam int unsigned GM_DEG_REST     = 90;
  localparam int unsigned GM_DEG_STEP     = 2;
  localparam int unsigned GM_LEN_MIN      = 16;
  localparam int unsigned GM_LEN_MAX      = 240;
  localparam int unsigned GM_EXT_STEP     = 4;
  localparam int unsigned GM_RET_FAST     = 4;
  localparam int unsigned GM_RET_SLOW     = 1;
  localparam int unsigned GM_DONE_TIMEOUT = 1023;

endpackage

// File: rtl/hook_draw_seq.sv
// rtl/hook_draw_seq.sv - per-frame draw handshake: update strobe, kick, wait for done
module hook_draw_seq
  import gm_hook_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = GM_DONE_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic frame_tick,
  input  logic draw_done,
  output logic update,
  output logic draw_enable,
  output logic frame_drop,
  output logic draw_timeout
);

  localparam int CW = $clog2(DONE_TIMEOUT + 1);

  phase_t          phase_q, phase_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            drop_d;
  logic            timeout_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase_q      <= PHASE_IDLE;
      wait_cnt_q   <= '0;
      frame_drop   <= 1'b0;
      draw_timeout <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      wait_cnt_q   <= wait_cnt_d;
      frame_drop   <= drop_d;
      draw_timeout <= timeout_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = draw_timeout;
    // Ticks are never queued; any tick seen outside IDLE is lost
    drop_d     = frame_tick && (phase_q != PHASE_IDLE);
    case (phase_q)
      PHASE_IDLE: begin
        if (frame_tick) phase_d = PHASE_UPDATE;
      end
      PHASE_UPDATE: begin
        phase_d = PHASE_KICK;
      end
      PHASE_KICK: begin
        phase_d    = PHASE_WAIT;
        wait_cnt_d = '0;
      end
      PHASE_WAIT: begin
        if (draw_done) begin
          phase_d = PHASE_IDLE;
        end else if (wait_cnt_q == CW'(DONE_TIMEOUT - 1)) begin
          phase_d   = PHASE_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: phase_d = PHASE_IDLE;
    endcase
  end

  assign update      = (phase_q == PHASE_UPDATE);
  assign draw_enable = (phase_q == PHASE_KICK);

endmodule

// File: rtl/hook_motion.sv
// rtl/hook_motion.sv - hook swing angle and rope length, advanced once per frame
module hook_motion
  import gm_hook_pkg::*;
#(
  parameter int unsigned DEG_MIN      = GM_DEG_MIN,
  parameter int unsigned DEG_MAX      = GM_DEG_MAX,
  parameter int unsigned DEG_STEP     = GM_DEG_STEP,
  parameter int unsigned LEN_MIN      = GM_LEN_MIN,
  parameter int unsigned LEN_MAX      = GM_LEN_MAX,
  parameter int unsigned EXT_STEP     = GM_EXT_STEP,
  parameter int unsigned RET_FAST     = GM_RET_FAST,
  parameter int unsigned RET_SLOW     = GM_RET_SLOW,
  parameter int unsigned DONE_TIMEOUT = GM_DONE_TIMEOUT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       hit,
  input  logic       draw_done,
  output logic [8:0] degree,
  output logic [9:0] length,
  output logic       draw_enable,
  output logic [1:0] mode,
  output logic       grabbed,
  output logic       retract_done,
  output logic       frame_drop,
  output logic       draw_timeout
);

  logic        update;
  mode_t       mode_q, mode_d;
  logic [8:0]  degree_q, degree_d;
  logic [9:0]  length_q, length_d;
  logic        dir_up_q, dir_up_d;
  logic        grabbed_q, grabbed_d;
  logic        fire_latch_q, fire_latch_d;
  logic        retract_done_q, retract_done_d;

  logic [9:0]         deg_up;
  logic signed [11:0] deg_dn;
  logic [10:0]        len_ext;
  logic signed [11:0] len_ret;

  hook_draw_seq #(
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_draw_seq (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .draw_done    (draw_done),
    .update       (update),
    .draw_enable  (draw_enable),
    .frame_drop   (frame_drop),
    .draw_timeout (draw_timeout)
  );

  // Widened so that overshooting a limit is visible before clamping
  assign deg_up  = {1'b0, degree_q} + 10'(DEG_STEP);
  assign deg_dn  = $signed({3'b000, degree_q}) - $signed(12'(DEG_STEP));
  assign len_ext = {1'b0, length_q} + 11'(EXT_STEP);
  assign len_ret = $signed({2'b00, length_q}) - $signed(12'(grabbed_q ? RET_SLOW : RET_FAST));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mode_q         <= MODE_SWING;
      degree_q       <= 9'(GM_DEG_REST);
      length_q       <= 10'(LEN_MIN);
      dir_up_q       <= 1'b1;
      grabbed_q      <= 1'b0;
      fire_latch_q   <= 1'b0;
      retract_done_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      degree_q       <= degree_d;
      length_q       <= length_d;
      dir_up_q       <= dir_up_d;
      grabbed_q      <= grabbed_d;
      fire_latch_q   <= fire_latch_d;
      retract_done_q <= retract_done_d;
    end
  end

  always_comb begin
    mode_d         = mode_q;
    degree_d       = degree_q;
    length_d       = length_q;
    dir_up_d       = dir_up_q;
    grabbed_d      = grabbed_q;
    retract_done_d = 1'b0;
    fire_latch_d   = fire_latch_q | (fire && (mode_q == MODE_SWING));
    if (update) begin
      case (mode_q)
        MODE_SWING: begin
          if (fire_latch_q) begin
            mode_d       = MODE_EXTEND;
            fire_latch_d = 1'b0;
          end else if (dir_up_q) begin
            if (deg_up >= 10'(DEG_MAX)) begin
              degree_d = 9'(DEG_MAX);
              dir_up_d = 1'b0;
            end else begin
              degree_d = deg_up[8:0];
            end
          end else begin
            if (deg_dn <= $signed(12'(DEG_MIN))) begin
              degree_d = 9'(DEG_MIN);
              dir_up_d = 1'b1;
            end else begin
              degree_d = deg_dn[8:0];
            end
          end
        end
        MODE_EXTEND: begin
          // A hit outranks reaching full length on the same frame
          if (hit) begin
            grabbed_d = 1'b1;
            mode_d    = MODE_RETRACT;
          end else if (len_ext >= 11'(LEN_MAX)) begin
            length_d = 10'(LEN_MAX);
            mode_d   = MODE_RETRACT;
          end else begin
            length_d = len_ext[9:0];
          end
        end
        MODE_RETRACT: begin
          if (len_ret <= $signed(12'(LEN_MIN))) begin
            length_d       = 10'(LEN_MIN);
            mode_d         = MODE_SWING;
            grabbed_d      = 1'b0;
            retract_done_d = 1'b1;
          end else begin
            length_d = len_ret[9:0];
          end
        end
        default: mode_d = MODE_SWING;
      endcase
    end
  end

  assign degree       = degree_q;
  assign length       = length_q;
  assign mode         = mode_q;
  assign grabbed      = grabbed_q;
  assign retract_done = retract_done_q;

endmodule

// File: tb/tb_hook_motion.sv
// tb/tb_hook_motion.sv - randomized bench against a frame-level hook model
module tb_hook_motion;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic       hit = 1'b0;
  logic       draw_done = 1'b0;
  logic [8:0] degree;
  logic [9:0] length;
  logic       draw_enable;
  logic [1:0] mode;
  logic       grabbed;
  logic       retract_done;
  logic       frame_drop;
  logic       draw_timeout;

  hook_motion dut (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .fire         (fire),
    .hit          (hit),
    .draw_done    (draw_done),
    .degree       (degree),
    .length       (length),
    .draw_enable  (draw_enable),
    .mode         (mode),
    .grabbed      (grabbed),
    .retract_done (retract_done),
    .frame_drop   (frame_drop),
    .draw_timeout (draw_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  int m_deg, m_dir, m_len, m_mode, m_grab, m_fire, m_rdone, m_tmo;
  int rd_seen, max_len, fire_deg, k;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_deg = 90; m_dir = 1; m_len = 16; m_mode = 0;
    m_grab = 0; m_fire = 0; m_rdone = 0; m_tmo = 0;
  endtask

  // One accepted frame, applied with plain integer arithmetic
  task automatic model_update(input bit h);
    int nd, nl;
    m_rdone = 0;
    if (m_mode == 0) begin
      if (m_fire != 0) begin
        m_mode = 1; m_fire = 0;
      end else begin
        nd = m_deg + 2 * m_dir;
        if (nd >= 160) begin m_deg = 160; m_dir = -1; end
        else if (nd <= 20) begin m_deg = 20; m_dir = 1; end
        else m_deg = nd;
      end
    end else if (m_mode == 1) begin
      if (h) begin
        m_grab = 1; m_mode = 2;
      end else begin
        nl = m_len + 4;
        if (nl >= 240) begin m_len = 240; m_mode = 2; end
        else m_len = nl;
      end
    end else begin
      nl = m_len - ((m_grab != 0) ? 1 : 4);
      if (nl <= 16) begin m_len = 16; m_mode = 0; m_grab = 0; m_rdone = 1; end
      else m_len = nl;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_degree"}, degree, m_deg);
    check_eq({tag, "_length"}, length, m_len);
    check_eq({tag, "_mode"}, mode, m_mode);
    check_eq({tag, "_grabbed"}, grabbed, m_grab);
    check_eq({tag, "_timeout"}, draw_timeout, m_tmo);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_degree"}, degree, 90);
    check_eq({tag, "_length"}, length, 16);
    check_eq({tag, "_mode"}, mode, 0);
    check_eq({tag, "_grabbed"}, grabbed, 0);
    check_eq({tag, "_enable"}, draw_enable, 0);
    check_eq({tag, "_rdone"}, retract_done, 0);
    check_eq({tag, "_drop"}, frame_drop, 0);
    check_eq({tag, "_timeout"}, draw_timeout, 0);
  endtask

  // variant: 0 plain, 1 tick during WAIT, 2 tick with draw_done, 3 reset in WAIT
  task automatic frame(input bit f, input bit h, input int dly, input int variant);
    if (f) begin
      fire = 1'b1; step(); fire = 1'b0;
      if (m_mode == 0) m_fire = 1;
    end
    hit = h; frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check_eq("kick_early", draw_enable, 0);
    step();
    model_update(h);
    hit = 1'b0;
    check_eq("kick", draw_enable, 1);
    check_eq("retract_done", retract_done, m_rdone);
    check_eq("drop_idle", frame_drop, 0);
    check_state("upd");
    if (retract_done) rd_seen++;
    if (length > max_len) max_len = int'(length);
    if (variant == 3) begin
      step(); resetn = 1'b0; step(); resetn = 1'b1;
      model_reset();
      check_reset("rst_wait");
      return;
    end
    step();
    check_eq("kick_once", draw_enable, 0);
    check_eq("rdone_once", retract_done, 0);
    if (variant == 1) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      check_eq("drop_wait", frame_drop, 1);
      step();
      check_eq("drop_pulse", frame_drop, 0);
    end
    repeat (dly - 1) step();
    check_state("hold");
    draw_done = 1'b1;
    if (variant == 2) frame_tick = 1'b1;
    step();
    draw_done = 1'b0; frame_tick = 1'b0;
    if (variant == 2) check_eq("drop_done", frame_drop, 1);
    if (variant != 0) begin
      repeat (3) begin
        step();
        check_eq("no_requeue", draw_enable, 0);
      end
      check_state("after_drop");
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rd_seen = 0; max_len = 0;
    repeat (3) step();
    resetn = 1'b1;
    check_reset("reset");

    for (int i = 0; i < 3; i++) begin
      frame(0, 0, 5, 0);
      check_eq("swing3", degree, 92 + 2 * i);
    end

    repeat (31) frame(0, 0, $urandom_range(1, 4), 0);
    check_eq("pre_limit", degree, 158);
    frame(0, 0, 2, 0);
    check_eq("limit_hi", degree, 160);
    frame(0, 0, 2, 0);
    check_eq("limit_flip", degree, 158);

    fire_deg = m_deg; rd_seen = 0; max_len = 0;
    frame(1, 0, 2, 0);
    check_eq("fire_mode", mode, 1);
    for (int i = 0; i < 200 && m_mode != 0; i++) frame(0, 0, $urandom_range(1, 4), 0);
    check_eq("nohit_max", max_len, 240);
    check_eq("nohit_rdone_count", rd_seen, 1);
    check_eq("nohit_degree", degree, fire_deg);

    rd_seen = 0;
    frame(1, 0, 2, 0);
    for (int i = 0; i < 60 && m_len < 100; i++) frame(0, 0, 2, 0);
    frame(0, 1, 2, 0);
    check_eq("hit_grab", grabbed, 1);
    check_eq("hit_len", length, 100);
    frame(0, 0, 1, 0);
    check_eq("slow_ret", length, 99);
    for (int i = 0; i < 200 && m_mode != 0; i++) frame(0, 0, 1, 0);
    check_eq("hit_rdone_count", rd_seen, 1);
    check_eq("hit_grab_clear", grabbed, 0);

    frame(1, 0, 2, 0);
    for (int i = 0; i < 60 && m_len < 236; i++) frame(0, 0, 1, 0);
    frame(0, 1, 1, 0);
    check_eq("maxhit_grab", grabbed, 1);
    check_eq("maxhit_len", length, 236);
    for (int i = 0; i < 300 && m_mode != 0; i++) frame(0, 0, 1, 0);

    frame(0, 0, 3, 1);
    frame(0, 0, 1, 2);
    frame(0, 0, 1, 0);

    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    model_update(0);
    check_eq("to_kick", draw_enable, 1);
    check_state("to_upd");
    k = 0;
    while (!draw_timeout && k < 1200) begin step(); k++; end
    check_eq("to_latency", k, 1024);
    check_eq("to_flag", draw_timeout, 1);
    m_tmo = 1;
    frame(0, 0, 2, 0);

    frame_tick = 1'b1; step(); frame_tick = 1'b0; resetn = 1'b0; step(); resetn = 1'b1;
    model_reset();
    check_reset("rst_upd");
    step();
    check_eq("rst_no_kick", draw_enable, 0);
    frame(1, 0, 2, 0);
    frame(0, 0, 2, 3);

    repeat (150) frame($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(1, 6), ($urandom_range(0, 19) == 0) ? 1 : 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
